dlyctl_rr: RTL and testbench

Round-robin scheduler sharing a single programmable delay timer among N requesters in the framer's timing path. Each requester raises a level request; the block grants one at a time, latches that requester's delay setting, counts it out, then issues a tagged done pulse. It sequences what would otherwise be N separate fixed-depth delay lines, so requesters can set the delay at run time instead of at elaboration.

---
 rtl/dlyctl_rr_if.sv | 25 ++
 rtl/dlyctl_rr.sv | 115 +++++++++++
 tb/tb_dlyctl_rr.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlyctl_rr_if.sv
// Request/grant bundle between the requesters and the shared delay timer.
// master = requester side, slave = dlyctl_rr.
interface dlyctl_rr_if #(
   parameter int N  = 4,
   parameter int DW = 4,
   parameter int IW = 2
);
   logic [N-1:0]    req;
   logic [N*DW-1:0] dly_cfg;
   logic            clr;
   logic [N-1:0]    gnt;
   logic            busy;
   logic            done;
   logic [IW-1:0]   done_id;

   modport master (
      output req, dly_cfg, clr,
      input  gnt, busy, done, done_id
   );

   modport slave (
      input  req, dly_cfg, clr,
      output gnt, busy, done, done_id
   );
endinterface

// File: rtl/dlyctl_rr.sv
// Round-robin scheduler that time-shares one programmable down-counter among
// N requesters, pulsing done with the owner's index when its delay expires.
module dlyctl_rr #(
   parameter int N  = 4,
   parameter int DW = 4,
   parameter int IW = 2
) (
   input  logic         clk,
   input  logic         rst,
   dlyctl_rr_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         SW     = IW + 1;

   logic [N-1:0][DW-1:0] cfg;
   assign cfg = bus.dly_cfg;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] cur_id_q, cur_id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [IW-1:0] done_id_q, done_id_d;

   logic          win_vld;
   logic [IW-1:0] win_id;
   logic [SW-1:0] sum;

   // Search starts one past the last winner, so it can only win again when alone.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      sum     = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, ptr_q} + SW'(k);
         if (sum >= SW'(N)) sum = sum - SW'(N);
         if (!win_vld && bus.req[sum[IW-1:0]]) begin
            win_vld = 1'b1;
            win_id  = sum[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_id_d  = cur_id_q;
      ptr_d     = ptr_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = '0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (!bus.clr && win_vld) begin
               state_d       = S_RUN;
               gnt_d[win_id] = 1'b1;
               cnt_d         = cfg[win_id];
               cur_id_d      = win_id;
               ptr_d         = win_id;
            end
         end
         S_RUN: begin
            if (bus.clr) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = cur_id_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         cur_id_q  <= '0;
         ptr_q     <= IW'(N - 1);
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_id_q  <= cur_id_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_dlyctl_rr.sv
// Scoreboard bench for dlyctl_rr: tasks queue the expected grant order and
// delays, a monitor pops them as gnt/done appear and checks id and cycle.
module tb_dlyctl_rr;
   localparam int N  = 4;
   localparam int DW = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dlyctl_rr_if #(.N(N), .DW(DW), .IW(IW)) bus ();

   dlyctl_rr #(.N(N), .DW(DW), .IW(IW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {int id; int dly; bit abort;} gexp_t;
   typedef struct {int id; int cyc;} dexp_t;

   gexp_t gq[$];
   dexp_t dq[$];
   int    gcyc_log[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   int    n_gnt  = 0;
   logic [N-1:0] last_gnt = '0;

   gexp_t         m_e;
   dexp_t         m_d;
   logic [N-1:0]  m_eg;
   logic [IW-1:0] m_id;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor, sampling on the falling edge.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (bus.gnt !== '0) begin
            n_gnt++;
            last_gnt = bus.gnt;
            gcyc_log.push_back(cyc);
            checks++;
            if (gq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_gnt got=%b at cyc %0d", bus.gnt, cyc);
            end else begin
               m_e  = gq.pop_front();
               m_eg = '0;
               m_eg[m_e.id] = 1'b1;
               if (bus.gnt !== m_eg) begin
                  errors++;
                  $display("FAIL gnt_order got=%b exp=%b", bus.gnt, m_eg);
               end
               if (!m_e.abort) dq.push_back('{m_e.id, cyc + m_e.dly + 1});
            end
         end
         if (bus.done === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done id=%0d at cyc %0d", bus.done_id, cyc);
            end else begin
               m_d  = dq.pop_front();
               m_id = m_d.id[IW-1:0];
               if (bus.done_id !== m_id) begin
                  errors++;
                  $display("FAIL done_id got=%0d exp=%0d", bus.done_id, m_id);
               end
               checks++;
               if (cyc != m_d.cyc) begin
                  errors++;
                  $display("FAIL done_cycle got=%0d exp=%0d", cyc, m_d.cyc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (n_gnt != base) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic drain(input bit drop, output bit ok);
      int seen;
      seen = n_gnt;
      for (int i = 0; i < 200 && (gq.size() != 0 || dq.size() != 0); i++) begin
         tick();
         if (drop && n_gnt != seen) begin
            seen    = n_gnt;
            bus.req = bus.req & ~last_gnt;
         end
      end
      ok = (gq.size() == 0 && dq.size() == 0);
   endtask

   task automatic set_dly(input int i, input int v);
      bus.dly_cfg[i*DW +: DW] = DW'(v);
   endtask

   task automatic test_reset();
      bus.req = '0; bus.clr = 1'b0; bus.dly_cfg = '0;
      rst = 1'b0;
      repeat (3) tick();
      checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.done_id !== '0) begin errors++; $display("FAIL reset_done_id got=%0d exp=0", bus.done_id); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int base; bit ok; logic exp_b;
      base = n_gnt;
      set_dly(0, 5);
      gq.push_back('{0, 5, 1'b0});
      bus.req = 4'b0001;
      wait_gnt(base, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_gnt_timeout got=none exp=gnt"); end
      bus.req = '0;
      for (int k = 0; k <= 7; k++) begin
         if (k > 0) tick();
         exp_b = (k <= 6);
         checks++;
         if (bus.busy !== exp_b) begin
            errors++;
            $display("FAIL single_busy cycle %0d got=%b exp=%b", k, bus.busy, exp_b);
         end
      end
      drain(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_drain got=pending exp=empty"); end
   endtask

   task automatic test_round_robin();
      int base, lg; bit ok;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      bus.dly_cfg = '0;
      base = n_gnt;
      lg   = gcyc_log.size();
      gq.push_back('{0, 0, 1'b0});
      gq.push_back('{1, 0, 1'b0});
      gq.push_back('{2, 0, 1'b0});
      gq.push_back('{3, 0, 1'b0});
      gq.push_back('{0, 0, 1'b0});
      bus.req = 4'b1111;
      for (int i = 0; i < 40 && n_gnt < base + 5; i++) tick();
      bus.req = '0;
      checks++; if (n_gnt < base + 5) begin errors++; $display("FAIL rr_grants got=%0d exp=5", n_gnt - base); end
      drain(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_drain got=pending exp=empty"); end
      for (int i = 1; i < 5 && lg + i < gcyc_log.size(); i++) begin
         checks++;
         if (gcyc_log[lg+i] - gcyc_log[lg+i-1] != 2) begin
            errors++;
            $display("FAIL rr_gap got=%0d exp=2", gcyc_log[lg+i] - gcyc_log[lg+i-1]);
         end
      end
   endtask

   task automatic test_fairness();
      int base; bit ok;
      bus.dly_cfg = '0;
      gq.push_back('{2, 0, 1'b0});
      bus.req = 4'b0100;
      drain(1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_setup got=pending exp=empty"); end
      base = n_gnt;
      gq.push_back('{3, 0, 1'b0});
      gq.push_back('{0, 0, 1'b0});
      gq.push_back('{1, 0, 1'b0});
      gq.push_back('{3, 0, 1'b0});
      bus.req = 4'b1011;
      for (int i = 0; i < 40 && n_gnt < base + 4; i++) tick();
      bus.req = '0;
      checks++; if (n_gnt < base + 4) begin errors++; $display("FAIL fair_grants got=%0d exp=4", n_gnt - base); end
      drain(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_drain got=pending exp=empty"); end
   endtask

   task automatic test_cfg_sample();
      int base; bit ok;
      base = n_gnt;
      set_dly(1, 3);
      gq.push_back('{1, 3, 1'b0});
      bus.req = 4'b0010;
      wait_gnt(base, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cfg_gnt_timeout got=none exp=gnt"); end
      set_dly(1, 15);
      bus.req = '0;
      drain(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cfg_drain got=pending exp=empty"); end
   endtask

   task automatic test_abort();
      int base; bit ok;
      base = n_gnt;
      set_dly(0, 10); set_dly(2, 0); set_dly(3, 0);
      gq.push_back('{0, 10, 1'b1});
      gq.push_back('{2, 0, 1'b0});
      gq.push_back('{3, 0, 1'b0});
      bus.req = 4'b0001;
      wait_gnt(base, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_gnt_timeout got=none exp=gnt"); end
      bus.req = 4'b1100;
      repeat (4) tick();
      bus.clr = 1'b1;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_c4 got=%b exp=1", bus.busy); end
      tick();
      bus.clr = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_c5 got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
      drain(1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_drain got=pending exp=empty"); end
   endtask

   task automatic test_async_reset();
      int base; bit ok;
      base = n_gnt;
      set_dly(0, 10); set_dly(3, 0);
      gq.push_back('{0, 10, 1'b1});
      bus.req = 4'b0001;
      wait_gnt(base, ok);
      checks++; if (!ok) begin errors++; $display("FAIL areset_gnt_timeout got=none exp=gnt"); end
      bus.req = '0;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL areset_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", bus.done); end
      checks++; if (bus.done_id !== '0) begin errors++; $display("FAIL areset_done_id got=%0d exp=0", bus.done_id); end
      repeat (2) tick();
      bus.req = 4'b1001;
      gq.push_back('{0, 10, 1'b0});
      gq.push_back('{3, 0, 1'b0});
      rst = 1'b1;
      drain(1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL areset_drain got=pending exp=empty"); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_cfg_sample();
      test_abort();
      test_async_reset();
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
